// File: rtl/tw_request_merger_pkg.sv
`default_nettype none
// tw_request_merger_pkg: shared header-field positions and merger state encoding.
// Revision 1.0
package tw_request_merger_pkg;

  localparam int TYPE_B                = 32;
  localparam int INSTREAM_COMPONENTS_H = 3;
  localparam int INSTREAM_COMPONENTS_L = 0;

  localparam logic GRANT_TW  = 1'b0;
  localparam logic GRANT_FIN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TW_HDR  = 3'd1,
    ST_TW_TID  = 3'd2,
    ST_FIN_CAP = 3'd3,
    ST_OUT_HDR = 3'd4,
    ST_OUT_TID = 3'd5
  } tw_merge_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tw_request_merger.sv
`default_nettype none
// tw_request_merger: round-robin merge of taskwait requests and finish notices into one 2-beat stream.
// Revision 1.0
module tw_request_merger
  import tw_request_merger_pkg::*;
#(
  parameter int MAX_ACCS = 16,
  localparam int ACC_BITS = $clog2(MAX_ACCS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [63:0]         twReq_TDATA,
  input  logic                twReq_TVALID,
  input  logic [ACC_BITS-1:0] twReq_TID,
  output logic                twReq_TREADY,
  input  logic [63:0]         finish_TDATA,
  input  logic                finish_TVALID,
  input  logic [ACC_BITS-1:0] finish_TID,
  output logic                finish_TREADY,
  output logic [63:0]         outStream_TDATA,
  output logic                outStream_TVALID,
  output logic [ACC_BITS-1:0] outStream_TID,
  input  logic                outStream_TREADY,
  output logic                outStream_TLAST,
  output logic [31:0]         twReqCount,
  output logic [31:0]         finishCount
);

  tw_merge_state_t     state;
  logic                last_grant;
  logic [63:0]         hdr_r;
  logic [63:0]         task_r;
  logic [ACC_BITS-1:0] tid_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_grant  <= GRANT_FIN;
      hdr_r       <= '0;
      task_r      <= '0;
      tid_r       <= '0;
      twReqCount  <= '0;
      finishCount <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // On a tie the source that did not win last time gets the grant.
          if (twReq_TVALID && (!finish_TVALID || last_grant == GRANT_FIN)) begin
            state      <= ST_TW_HDR;
            last_grant <= GRANT_TW;
          end else if (finish_TVALID) begin
            state      <= ST_FIN_CAP;
            last_grant <= GRANT_FIN;
          end
        end
        ST_TW_HDR: begin
          if (twReq_TVALID) begin
            hdr_r <= twReq_TDATA;
            tid_r <= twReq_TID;
            state <= ST_TW_TID;
          end
        end
        ST_TW_TID: begin
          if (twReq_TVALID) begin
            task_r <= twReq_TDATA;
            state  <= ST_OUT_HDR;
          end
        end
        ST_FIN_CAP: begin
          if (finish_TVALID) begin
            task_r <= finish_TDATA;
            tid_r  <= finish_TID;
            hdr_r  <= '0;
            state  <= ST_OUT_HDR;
          end
        end
        ST_OUT_HDR: begin
          if (outStream_TREADY) state <= ST_OUT_TID;
        end
        ST_OUT_TID: begin
          if (outStream_TREADY) begin
            state <= ST_IDLE;
            if (hdr_r[TYPE_B]) twReqCount  <= sat_inc(twReqCount);
            else               finishCount <= sat_inc(finishCount);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign twReq_TREADY     = (state == ST_TW_HDR) || (state == ST_TW_TID);
  assign finish_TREADY    = (state == ST_FIN_CAP);
  assign outStream_TVALID = (state == ST_OUT_HDR) || (state == ST_OUT_TID);
  assign outStream_TLAST  = (state == ST_OUT_TID);
  assign outStream_TDATA  = (state == ST_OUT_TID) ? task_r : hdr_r;
  assign outStream_TID    = tid_r;

endmodule
`default_nettype wire
